// File: rtl/bird_position_if.sv
// Handshake bundle between the frame controller and bird_position.
// master drives start/tick/velocity and observes row/crash/running/airtime;
// slave is the bird_position side. No clock is carried; clk/rst stay plain ports.
interface bird_position_if #(
  parameter int ROWS = 16
);
  localparam int RW = $clog2(ROWS);

  logic          start;     // one-cycle run launch / relaunch
  logic          tick;      // one-cycle frame enable
  logic [2:0]    velocity;  // signed rows per update, positive = upward
  logic [RW-1:0] row;       // current bird row, 0 = ceiling
  logic          crash;     // high while crashed
  logic          running;   // high while flying
  logic [7:0]    airtime;   // saturating count of completed updates

  modport master (
    output start, tick, velocity,
    input  row, crash, running, airtime
  );

  modport slave (
    input  start, tick, velocity,
    output row, crash, running, airtime
  );
endinterface

// File: rtl/bird_position.sv
// Purpose: integrates signed per-frame velocity into a playfield row, detects
//          floor/ceiling crashes, and counts completed position updates.
// Latency: 1 cycle from start/tick edge to registered outputs; no backpressure
//          (tick and start are single-cycle enables, accepted every cycle).
// Ports:   CLK, RST_N (async active-low); bus (slave): start, tick, velocity in;
//          row, crash, running, airtime out.
module bird_position #(
  parameter int ROWS       = 16,
  parameter int START_ROW  = 8,
  parameter int UPDATE_DIV = 1
) (
  input  logic             CLK,
  input  logic             RST_N,
  bird_position_if.slave   bus
);

  localparam int RW = $clog2(ROWS);
  // Two guard bits: one absorbs the +4 overshoot past the floor, one is the sign.
  localparam int NW = RW + 2;

  localparam logic [RW-1:0]        START_V  = RW'(START_ROW);
  localparam logic [RW-1:0]        ROW_MAX  = RW'(ROWS - 1);
  localparam logic signed [NW-1:0] NEXT_MAX = NW'(ROWS - 1);
  localparam logic [3:0]           DIV_LAST = 4'(UPDATE_DIV - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FLY   = 2'd1,
    CRASH = 2'd2
  } state_t;

  state_t        state_q,   state_d;
  logic [RW-1:0] row_q,     row_d;
  logic [7:0]    airtime_q, airtime_d;
  logic [3:0]    div_q,     div_d;
  logic          crash_q,   crash_d;
  logic          running_q, running_d;

  logic signed [NW-1:0] vel_ext;
  logic signed [NW-1:0] next_row;

  always_comb begin
    state_d   = state_q;
    row_d     = row_q;
    airtime_d = airtime_q;
    div_d     = div_q;

    vel_ext  = {{(NW-3){bus.velocity[2]}}, bus.velocity};
    // Upward velocity moves toward row 0, so it is subtracted.
    next_row = $signed({2'b00, row_q}) - vel_ext;

    if (bus.start) begin
      // start takes priority over a coincident tick, which is dropped.
      state_d   = FLY;
      row_d     = START_V;
      airtime_d = 8'd0;
      div_d     = 4'd0;
    end else if (state_q == FLY && bus.tick) begin
      if (div_q == DIV_LAST) begin
        div_d = 4'd0;
        if (next_row[NW-1]) begin
          row_d   = '0;
          state_d = CRASH;
        end else if (next_row > NEXT_MAX) begin
          row_d   = ROW_MAX;
          state_d = CRASH;
        end else begin
          row_d = next_row[RW-1:0];
          if (airtime_q != 8'hFF) begin
            airtime_d = airtime_q + 8'd1;
          end
        end
      end else begin
        div_d = div_q + 4'd1;
      end
    end

    crash_d   = (state_d == CRASH);
    running_d = (state_d == FLY);
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q   <= IDLE;
      row_q     <= START_V;
      airtime_q <= 8'd0;
      div_q     <= 4'd0;
      crash_q   <= 1'b0;
      running_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      row_q     <= row_d;
      airtime_q <= airtime_d;
      div_q     <= div_d;
      crash_q   <= crash_d;
      running_q <= running_d;
    end
  end

  assign bus.row     = row_q;
  assign bus.crash   = crash_q;
  assign bus.running = running_q;
  assign bus.airtime = airtime_q;

endmodule

// File: tb/tb_bird_position.sv
// Directed scoreboard bench for bird_position: instance A uses UPDATE_DIV=1,
// instance B uses UPDATE_DIV=3. Stimulus pushes hand-computed expectations;
// a negedge monitor pops and compares them against the selected instance.
module tb_bird_position;

  logic CLK;
  logic RST_N;

  bird_position_if #(.ROWS(16)) if_a ();
  bird_position_if #(.ROWS(16)) if_b ();

  bird_position #(.ROWS(16), .START_ROW(8), .UPDATE_DIV(1)) u_dut_a (
    .CLK   (CLK),
    .RST_N (RST_N),
    .bus   (if_a.slave)
  );

  bird_position #(.ROWS(16), .START_ROW(8), .UPDATE_DIV(3)) u_dut_b (
    .CLK   (CLK),
    .RST_N (RST_N),
    .bus   (if_b.slave)
  );

  typedef struct {
    int    sel;
    int    row;
    int    crash;
    int    running;
    int    air;
    string name;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_errors = 0;

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Monitor: outputs are stable around the negedge, half a period after the edge.
  always @(negedge CLK) begin
    while (exp_q.size() > 0) begin
      exp_t e;
      int   r, c, ru, a;
      e = exp_q.pop_front();
      if (e.sel == 0) begin
        r = int'(if_a.row); c = int'(if_a.crash); ru = int'(if_a.running); a = int'(if_a.airtime);
      end else begin
        r = int'(if_b.row); c = int'(if_b.crash); ru = int'(if_b.running); a = int'(if_b.airtime);
      end
      n_checks++;
      if (r != e.row || c != e.crash || ru != e.running || a != e.air) begin
        n_errors++;
        $display("FAIL %s (dut %0d): got row=%0d crash=%0d running=%0d airtime=%0d, want row=%0d crash=%0d running=%0d airtime=%0d",
                 e.name, e.sel, r, c, ru, a, e.row, e.crash, e.running, e.air);
      end
    end
  end

  task automatic push(input int sel, input int row, input int crash, input int running,
                      input int air, input string name);
    exp_t e;
    e.sel = sel; e.row = row; e.crash = crash; e.running = running; e.air = air; e.name = name;
    exp_q.push_back(e);
  endtask

  // One clock of stimulus on the selected instance, then the expected outputs.
  task automatic step(input int sel, input logic s, input logic t, input logic [2:0] v,
                      input int row, input int crash, input int running, input int air,
                      input string name);
    @(negedge CLK);
    if (sel == 0) begin
      if_a.start = s; if_a.tick = t; if_a.velocity = v;
    end else begin
      if_b.start = s; if_b.tick = t; if_b.velocity = v;
    end
    @(posedge CLK);
    #1;
    if_a.start = 1'b0; if_a.tick = 1'b0; if_a.velocity = 3'b000;
    if_b.start = 1'b0; if_b.tick = 1'b0; if_b.velocity = 3'b000;
    push(sel, row, crash, running, air, name);
  endtask

  // Reset asserted between edges; reset values must appear before any clock edge.
  task automatic async_reset(input string name);
    @(posedge CLK);
    #2;
    RST_N = 1'b0;
    push(0, 8, 0, 0, 0, name);
    push(1, 8, 0, 0, 0, name);
    @(posedge CLK);
    @(negedge CLK);
    RST_N = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    RST_N = 1'b0;
    if_a.start = 1'b0; if_a.tick = 1'b0; if_a.velocity = 3'b000;
    if_b.start = 1'b0; if_b.tick = 1'b0; if_b.velocity = 3'b000;
    #3;
    push(0, 8, 0, 0, 0, "reset_a");
    push(1, 8, 0, 0, 0, "reset_b");
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    RST_N = 1'b1;

    // ---- Instance A, UPDATE_DIV=1 ----
    step(0, 0, 1, 3'b001,  8, 0, 0, 0, "idle_tick_ignored");
    step(0, 1, 0, 3'b000,  8, 0, 1, 0, "start");
    step(0, 0, 1, 3'b001,  7, 0, 1, 1, "up1_a");
    step(0, 0, 1, 3'b001,  6, 0, 1, 2, "up1_b");
    step(0, 0, 1, 3'b001,  5, 0, 1, 3, "up1_c");
    step(0, 1, 0, 3'b000,  8, 0, 1, 0, "restart_in_fly");
    step(0, 0, 1, 3'b101, 11, 0, 1, 1, "down3_a");
    step(0, 0, 1, 3'b101, 14, 0, 1, 2, "down3_b");
    step(0, 0, 1, 3'b101, 15, 1, 0, 2, "floor_crash");
    step(0, 0, 1, 3'b101, 15, 1, 0, 2, "crash_frozen");
    step(0, 1, 0, 3'b000,  8, 0, 1, 0, "start_from_crash");
    step(0, 0, 1, 3'b011,  5, 0, 1, 1, "up3_a");
    step(0, 0, 1, 3'b011,  2, 0, 1, 2, "up3_b");
    step(0, 0, 1, 3'b010,  0, 0, 1, 3, "land_row0");
    step(0, 0, 1, 3'b001,  0, 1, 0, 3, "ceiling_crash");
    step(0, 1, 0, 3'b000,  8, 0, 1, 0, "start_again");
    step(0, 0, 1, 3'b100, 12, 0, 1, 1, "down4");
    step(0, 0, 1, 3'b100, 15, 1, 0, 1, "down4_crash");
    step(0, 1, 0, 3'b000,  8, 0, 1, 0, "start_pre_rst");
    step(0, 0, 1, 3'b001,  7, 0, 1, 1, "up_pre_rst");
    async_reset("async_reset_midrun");
    step(0, 0, 1, 3'b001,  8, 0, 0, 0, "idle_after_reset");

    // ---- Instance B, UPDATE_DIV=3 ----
    step(1, 1, 0, 3'b000, 8, 0, 1, 0, "b_start");
    step(1, 0, 1, 3'b001, 8, 0, 1, 0, "b_t1");
    step(1, 0, 1, 3'b001, 8, 0, 1, 0, "b_t2");
    step(1, 0, 1, 3'b001, 7, 0, 1, 1, "b_t3");
    step(1, 0, 1, 3'b001, 7, 0, 1, 1, "b_t4");
    step(1, 0, 1, 3'b001, 7, 0, 1, 1, "b_t5");
    step(1, 0, 1, 3'b001, 6, 0, 1, 2, "b_t6");
    step(1, 0, 1, 3'b001, 6, 0, 1, 2, "b_t7");
    step(1, 0, 1, 3'b001, 6, 0, 1, 2, "b_t8");
    step(1, 1, 1, 3'b001, 8, 0, 1, 0, "b_start_wins");
    step(1, 0, 1, 3'b001, 8, 0, 1, 0, "b_div_cleared_1");
    step(1, 0, 1, 3'b001, 8, 0, 1, 0, "b_div_cleared_2");
    step(1, 0, 1, 3'b001, 7, 0, 1, 1, "b_div_cleared_3");

    // ---- Airtime saturation on instance A ----
    step(0, 1, 0, 3'b000, 8, 0, 1, 0, "sat_start");
    for (int i = 1; i <= 260; i++) begin
      step(0, 0, 1, 3'b000, 8, 0, 1, (i > 255) ? 255 : i, "sat");
    end

    repeat (3) @(posedge CLK);
    if (exp_q.size() != 0) begin
      n_errors++;
      $display("FAIL drain: %0d expectations left unchecked, want 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/bird_position.md
# bird_position

Integrates the bird's signed per-frame velocity into a vertical row position on the LED playfield and detects floor/ceiling crashes. Sits downstream of the velocity state machine: it consumes the 3-bit two's-complement velocity word and produces the row index used by the display and collision logic. It also holds a small run/crash state machine and counts frames survived.

## Interface
- ROWS, 16: playfield height in rows; row 0 = top (ceiling), ROWS-1 = bottom (floor). Must be a power of two, 4..64.
- START_ROW, 8: row loaded on reset and on every start.
- UPDATE_DIV, 1: number of frame ticks per position update (1..15).

- CLK  in  1  system clock, all state on rising edge.
- RST_N  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle pulse; launches or relaunches a run.
- tick  in  1  one-cycle frame enable.
- velocity  in  3  signed two's complement, rows per update; positive = upward.
- row  out  $clog2(ROWS)  current bird row.
- crash  out  1  high while in CRASH.
- running  out  1  high while in FLY.
- airtime  out  8  position updates completed in the current run, saturating at 255.

## Operation
- States: IDLE, FLY, CRASH. Reset -> IDLE, row = START_ROW, crash = 0, running = 0, airtime = 0, divider = 0.
- IDLE: hold row. start -> FLY, row = START_ROW, airtime = 0, divider = 0.
- FLY: each tick increments divider; on the tick where divider reaches UPDATE_DIV-1, divider returns to 0 and an update occurs. Ticks with divider < UPDATE_DIV-1 change nothing else.
- Update arithmetic: next = row - sext(velocity), computed at $clog2(ROWS)+2 bits signed (upward velocity decreases row index). All 8 velocity codes are legal; 3'b100 = -4.
- If 0 <= next <= ROWS-1: row = next; airtime += 1 (stays 255 once reached).
- If next < 0: row = 0, state -> CRASH. If next > ROWS-1: row = ROWS-1, state -> CRASH. airtime is not incremented on the crashing update.
- Landing exactly on row 0 or ROWS-1 is not a crash.
- CRASH: row, airtime frozen; ticks ignored. start -> FLY with the same reload as IDLE.
- start in FLY: restart the run (reload row, airtime, divider), stay in FLY.
- start and tick in the same cycle: start wins; that tick is discarded.
- velocity is sampled only on update cycles; no other input qualification.

## Timing
- All outputs registered; no combinational input-to-output paths.
- start at edge N -> running = 1, row = START_ROW visible after edge N.
- Update tick sampled at edge N -> new row, airtime, crash visible after edge N; latency 1 cycle.
- crash and running are mutually exclusive; both 0 in IDLE.
- RST_N low at any time, including mid-run or in CRASH, forces the reset values immediately (asynchronous), independent of CLK; deassertion takes effect at the next rising edge.
- Back-to-back ticks (every cycle) are supported; one update per qualifying tick.

## Test plan
- Reset then start, UPDATE_DIV=1, velocity=+1 for 3 ticks -> row 8,7,6,5; airtime 3; running=1.
- From row 8, velocity=-3 (3'b101) each tick -> rows 11,14, next tick computes 17 -> row 15, crash=1, running=0, airtime=2; further ticks change nothing.
- From row 2, velocity=+2 -> row 0, no crash; next tick velocity=+1 -> row 0, crash=1.
- UPDATE_DIV=3, velocity=+1, 6 ticks -> row changes only on ticks 3 and 6 (8->7->6); start and tick in the same cycle -> row=8, divider=0, no update.
- In CRASH, pulse start -> row=8, airtime=0, running=1 next cycle; assert RST_N low mid-run between clock edges -> outputs at reset values immediately, state IDLE.
- Run 260 updates with velocity=0 -> row stays 8, airtime saturates at 255.
